fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the 16-deep byte FIFO and sends each byte as an asynchronous UART frame.
- FIFO side: pulls one byte at a time with a single-cycle read strobe and samples the registered FIFO data one cycle later.
- Line side: drives tx with start bit, data (LSB first), optional parity, and stop bit(s).
- Sits directly downstream of the FIFO; the FIFO's rd and empty connect here.

---
 rtl/fifo_uart_pkg.sv | 24 ++
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/fifo_uart_tx.sv | 137 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int DATA_W   = 8;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Even parity makes the total count of ones even, so it is the plain XOR.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last clk of each bit, pre_tick the one before it.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick     = (cnt_reg == LAST);
    assign pre_tick = (cnt_reg == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO one entry at a time and serialises each byte as a UART frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $fatal(1, "fifo_uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $fatal(1, "fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    tx_state_t         state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_reg;
    logic [2:0]        bit_idx_reg;
    logic              stop_idx_reg;
    logic              tick;
    logic              pre_tick;
    logic              baud_clr;
    logic              last_stop;

    // Holding the counter at zero outside the frame makes START begin on a fresh period.
    assign baud_clr  = (state_reg == ST_IDLE) || (state_reg == ST_FETCH) || (state_reg == ST_LOAD);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_reg;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (baud_clr),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            fifo_rd      <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            byte_done    <= 1'b0;
        end else begin
            fifo_rd   <= 1'b0;
            byte_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (en && !fifo_empty) begin
                        state_reg <= ST_FETCH;
                        fifo_rd   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_FETCH: state_reg <= ST_LOAD;
                ST_LOAD: begin
                    shift_reg <= fifo_dout;
                    par_reg   <= parity_bit(fifo_dout, PARITY);
                    tx        <= 1'b0;
                    state_reg <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx          <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx_reg == 3'd7) begin
                            if (PARITY != PAR_NONE) begin
                                tx        <= par_reg;
                                state_reg <= ST_PARITY;
                            end else begin
                                tx           <= 1'b1;
                                stop_idx_reg <= 1'b0;
                                state_reg    <= ST_STOP;
                            end
                        end else begin
                            tx          <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx           <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Registered pulse is armed one clk early so it lands on the final stop cycle.
                    if (pre_tick && last_stop) begin
                        byte_done <= 1'b1;
                    end
                    if (tick) begin
                        if (last_stop) begin
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: three transmitters (no parity / even / odd + 2 stop bits), each fed by a small FIFO model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_rd;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] byte_done;
    logic [7:0] fifo_dout [3];

    logic [7:0] mem [3][16];
    logic [4:0] wp [3] = '{5'd0, 5'd0, 5'd0};
    logic [4:0] rp [3] = '{5'd0, 5'd0, 5'd0};
    int         rd_cnt [3] = '{0, 0, 0};
    int         done_cnt [3] = '{0, 0, 0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        assign fifo_empty[gi] = (wp[gi] == rp[gi]);

        always @(posedge clk) begin
            if (fifo_rd[gi] && (wp[gi] != rp[gi])) begin
                fifo_dout[gi] <= mem[gi][rp[gi][3:0]];
                rp[gi]        <= rp[gi] + 5'd1;
            end
            if (fifo_rd[gi])   rd_cnt[gi]   <= rd_cnt[gi] + 1;
            if (byte_done[gi]) done_cnt[gi] <= done_cnt[gi] + 1;
        end

        fifo_uart_tx #(
            .CLKS_PER_BIT(4),
            .PARITY      (gi),
            .STOP_BITS   ((gi == 2) ? 2 : 1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en[gi]),
            .fifo_empty(fifo_empty[gi]),
            .fifo_dout (fifo_dout[gi]),
            .fifo_rd   (fifo_rd[gi]),
            .tx        (tx[gi]),
            .busy      (busy[gi]),
            .byte_done (byte_done[gi])
        );
    end

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wp[k][3:0]] = b;
        wp[k] = wp[k] + 5'd1;
    endtask

    // Leaves the bench at the negedge of the FETCH cycle; waited = clocks stepped.
    task automatic wait_rd(input int k, output int waited, output bit ok);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!fifo_rd[k] && waited < 60);
        ok = fifo_rd[k];
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_rd k=%0d: fifo_rd=%b after %0d clk, required 1", k, fifo_rd[k], waited);
        end
    endtask

    // Walks LOAD, every bit clock of the frame and the following IDLE clock.
    task automatic expect_frame(input int k, input logic [7:0] b, input logic par, input int drop_at);
        logic exp_bits [12];
        int   nb;
        int   cyc;
        logic exp_done;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
        nb = 9;
        if (k != 0) begin
            exp_bits[nb] = par;
            nb = nb + 1;
        end
        exp_bits[nb] = 1'b1;
        nb = nb + 1;
        if (k == 2) begin
            exp_bits[nb] = 1'b1;
            nb = nb + 1;
        end

        @(negedge clk);
        n_checks++;
        if (tx[k] !== 1'b1 || busy[k] !== 1'b1 || fifo_rd[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL load k=%0d byte=%02h: tx=%b busy=%b rd=%b, required tx=1 busy=1 rd=0",
                     k, b, tx[k], busy[k], fifo_rd[k]);
        end

        cyc = 0;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                cyc++;
                if (cyc == drop_at) en[k] = 1'b0;
                exp_done = (i == nb - 1) && (c == 3);
                n_checks++;
                if (tx[k] !== exp_bits[i] || busy[k] !== 1'b1 || byte_done[k] !== exp_done) begin
                    n_fail++;
                    $display("FAIL frame k=%0d byte=%02h bit=%0d clk=%0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=%b",
                             k, b, i, c, tx[k], busy[k], byte_done[k], exp_bits[i], exp_done);
                end
            end
        end

        @(negedge clk);
        n_checks++;
        if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || byte_done[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_frame k=%0d byte=%02h: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     k, b, tx[k], busy[k], byte_done[k]);
        end
    endtask

    task automatic test_reset();
        int w;
        bit ok;
        bit bad;
        rst = 1'b0;
        en  = 3'b000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 3'b111 || busy !== 3'b000 || fifo_rd !== 3'b000 || byte_done !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b busy=%b rd=%b done=%b, required 111 000 000 000",
                     tx, busy, fifo_rd, byte_done);
        end
        rst = 1'b1;

        push(0, 8'h00);
        en[0] = 1'b1;
        wait_rd(0, w, ok);
        if (ok) begin
            repeat (7) @(negedge clk);
            n_checks++;
            if (tx[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL pre_reset_tx: tx=%b, required 0", tx[0]);
            end
            rst = 1'b0;
            #1;
            n_checks++;
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_rd[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset: tx=%b busy=%b rd=%b, required tx=1 busy=0 rd=0",
                         tx[0], busy[0], fifo_rd[0]);
            end
            @(negedge clk);
            rst = 1'b1;
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL idle_after_reset: activity seen, required idle with empty FIFO");
        end
        en[0] = 1'b0;
    endtask

    task automatic test_single_byte();
        int w;
        bit ok;
        int rd0;
        int dn0;
        rd0 = rd_cnt[0];
        dn0 = done_cnt[0];
        push(0, 8'hA5);
        en[0] = 1'b1;
        wait_rd(0, w, ok);
        if (ok) expect_frame(0, 8'hA5, 1'b0, -1);
        en[0] = 1'b0;
        n_checks++;
        if (rd_cnt[0] - rd0 != 1 || done_cnt[0] - dn0 != 1) begin
            n_fail++;
            $display("FAIL single_pulses: rd=%0d done=%0d, required 1 1", rd_cnt[0] - rd0, done_cnt[0] - dn0);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        bit ok;
        bit bad;
        int rd0;
        rd0 = rd_cnt[0];
        push(0, 8'h00);
        push(0, 8'hFF);
        en[0] = 1'b1;
        wait_rd(0, w, ok);
        if (ok) expect_frame(0, 8'h00, 1'b0, -1);
        wait_rd(0, w, ok);
        n_checks++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL b2b_gap: fetch came %0d clk after idle clk, required 1", w);
        end
        if (ok) expect_frame(0, 8'hFF, 1'b0, -1);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_empty[0] !== 1'b1 || fifo_rd[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || rd_cnt[0] - rd0 != 2) begin
            n_fail++;
            $display("FAIL b2b_after: rd pulses=%0d stray=%b, required 2 and idle", rd_cnt[0] - rd0, bad);
        end
        en[0] = 1'b0;
    endtask

    task automatic test_parity_stop();
        int w;
        bit ok;
        push(1, 8'h07);
        en[1] = 1'b1;
        wait_rd(1, w, ok);
        if (ok) expect_frame(1, 8'h07, 1'b1, -1);
        en[1] = 1'b0;
        push(2, 8'h07);
        en[2] = 1'b1;
        wait_rd(2, w, ok);
        if (ok) expect_frame(2, 8'h07, 1'b0, -1);
        en[2] = 1'b0;
    endtask

    task automatic test_enable();
        int w;
        bit ok;
        bit bad;
        push(0, 8'h3C);
        push(0, 8'h5A);
        en[0] = 1'b1;
        wait_rd(0, w, ok);
        if (ok) expect_frame(0, 8'h3C, 1'b0, 10);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd[0] !== 1'b0 || fifo_empty[0] !== 1'b0 || tx[0] !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL enable_hold: fetch or line activity with en=0, required none");
        end
        en[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fifo_rd[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_resume: rd=%b one clk after en, required 1", fifo_rd[0]);
        end else begin
            expect_frame(0, 8'h5A, 1'b0, -1);
        end
        en[0] = 1'b0;
    endtask

    task automatic test_drain();
        int w;
        bit ok;
        int rd0;
        int dn0;
        rd0 = rd_cnt[0];
        dn0 = done_cnt[0];
        for (int i = 0; i < 16; i++) push(0, 8'(i));
        en[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_rd(0, w, ok);
            if (!ok) break;
            expect_frame(0, 8'(i), 1'b0, -1);
            n_checks++;
            if (fifo_empty[0] !== (i == 15)) begin
                n_fail++;
                $display("FAIL drain_empty after frame %0d: empty=%b, required %b", i, fifo_empty[0], (i == 15));
            end
        end
        en[0] = 1'b0;
        n_checks++;
        if (rd_cnt[0] - rd0 != 16 || done_cnt[0] - dn0 != 16) begin
            n_fail++;
            $display("FAIL drain_pulses: rd=%0d done=%0d, required 16 16", rd_cnt[0] - rd0, done_cnt[0] - dn0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity_stop();
        test_enable();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
